// File: rtl/riscv_pkg.sv
// Shared constants for the RV32I decode/issue slice: ALU op codes, opcodes,
// issue FSM states and the decoded-operation record.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SLL = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd4;
  localparam logic [3:0] ALU_SRL = 4'd5;
  localparam logic [3:0] ALU_XOR = 4'd7;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  // What DECODE hands to the ALU for one instruction.
  typedef struct packed {
    logic [3:0]      ctrl;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            illegal;
  } issue_t;

endpackage

// File: rtl/alu_issue_if.sv
// Instruction handshake plus the ALU request/answer bus of alu_issue.
// master: the issue unit (drives the ALU); slave: instruction source and ALU.
interface alu_issue_if;
  import riscv_pkg::*;

  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic            instr_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_ans;
  logic            done;
  logic            illegal;

  modport master (
    input  instr_valid, instr, alu_ans,
    output instr_ready, alu_control, alu_a, alu_b, done, illegal
  );

  modport slave (
    output instr_valid, instr, alu_ans,
    input  instr_ready, alu_control, alu_a, alu_b, done, illegal
  );

endinterface

// File: rtl/regfile.sv
// 32x32 integer register file: two operand read ports, one debug read port,
// one synchronous write port; x0 always reads zero.
module regfile
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata2,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  logic [XLEN-1:0] mem [NREGS];

  // NOTE: the array is cleared on reset because software expects every
  // register to read zero afterwards; this costs a reset flop per bit
  // and rules out mapping the array onto a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1   = (raddr1   == 5'd0) ? '0 : mem[raddr1];
  assign rdata2   = (raddr2   == 5'd0) ? '0 : mem[raddr2];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Multi-cycle RV32I integer issue unit: accepts one instruction, decodes it,
// drives the external ALU, and writes the answer back to rd four cycles later.
module alu_issue
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  alu_issue_if.master     bus,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] instr_q;
  issue_t          issue_q, dec;
  logic [XLEN-1:0] result_q;

  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] operand2;
  logic [3:0]      op;
  logic            legal;
  logic            wb_we;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  logic [XLEN-1:0] imm_s;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign funct7 = instr_q[31:25];
  assign imm_s  = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};

  regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (wb_we),
    .waddr    (rd),
    .wdata    (result_q),
    .raddr1   (rs1),
    .rdata1   (rs1_val),
    .raddr2   (rs2),
    .rdata2   (rs2_val),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default up front so
  // that no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d         = state_q;
    bus.instr_ready = 1'b0;
    bus.done        = 1'b0;
    bus.illegal     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) state_d = ST_DECODE;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_WB;
      ST_WB: begin
        bus.done    = 1'b1;
        bus.illegal = issue_q.illegal;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Instruction decode of the latched word to an ALU op and its legality.
  always_comb begin
    op    = ALU_AND;
    legal = 1'b0;
    unique case (opcode)
      OP_R: begin
        unique case ({funct7, funct3})
          {7'b0000000, 3'b000}: begin op = ALU_ADD; legal = 1'b1; end
          {7'b0100000, 3'b000}: begin op = ALU_SUB; legal = 1'b1; end
          {7'b0000000, 3'b001}: begin op = ALU_SLL; legal = 1'b1; end
          {7'b0000000, 3'b100}: begin op = ALU_XOR; legal = 1'b1; end
          {7'b0000000, 3'b101}: begin op = ALU_SRL; legal = 1'b1; end
          {7'b0000000, 3'b110}: begin op = ALU_OR;  legal = 1'b1; end
          {7'b0000000, 3'b111}: begin op = ALU_AND; legal = 1'b1; end
          default: ;
        endcase
      end
      OP_I: begin
        unique case (funct3)
          3'b000: begin op = ALU_ADD; legal = 1'b1; end
          3'b100: begin op = ALU_XOR; legal = 1'b1; end
          3'b110: begin op = ALU_OR;  legal = 1'b1; end
          3'b111: begin op = ALU_AND; legal = 1'b1; end
          3'b001: begin op = ALU_SLL; legal = (funct7 == 7'd0); end
          3'b101: begin op = ALU_SRL; legal = (funct7 == 7'd0); end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Operand assembly. The ALU shifts by its whole b input, so shift amounts
  // are trimmed to five bits here; for SLLI/SRLI imm_s[4:0] is the shamt.
  always_comb begin
    operand2 = (opcode == OP_I) ? imm_s : rs2_val;
    if ((op == ALU_SLL) || (op == ALU_SRL)) operand2 = {{(XLEN-5){1'b0}}, operand2[4:0]};
    dec.ctrl    = legal ? op       : ALU_AND;
    dec.a       = legal ? rs1_val  : '0;
    dec.b       = legal ? operand2 : '0;
    dec.illegal = ~legal;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q  <= '0;
      issue_q  <= '0;
      result_q <= '0;
    end else begin
      if (bus.instr_valid && bus.instr_ready) instr_q  <= bus.instr;
      if (state_q == ST_DECODE)               issue_q  <= dec;
      if (state_q == ST_EXEC)                 result_q <= bus.alu_ans;
    end
  end

  assign wb_we           = (state_q == ST_WB) && !issue_q.illegal && (rd != 5'd0);
  assign bus.alu_control = issue_q.ctrl;
  assign bus.alu_a       = issue_q.a;
  assign bus.alu_b       = issue_q.b;

endmodule
